// File: rtl/alu_share_pkg.sv
// Shared types for the two-requester ALU arbiter: opcodes, FSM states, opcode width.
package alu_share_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpAnd  = 3'b010,
        OpOr   = 3'b011,
        OpXor  = 3'b100,
        OpNot  = 3'b101,
        OpPass = 3'b110,
        OpSltu = 3'b111
    } op_e;

    typedef enum logic [0:0] {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two issue front ends, the arbiter and the consumer.
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    import alu_share_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [OP_W-1:0]  req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [OP_W-1:0]  req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_zero;
    logic             rsp_carry;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_carry
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_carry
    );

endinterface

// File: rtl/alu_share_core.sv
// Combinational ALU: one op per cycle on the selected operand set, with carry and zero flags.
module alu_share_core
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic             carry_o,
    output logic             zero_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           lt;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};
    // The borrow out of the widened subtract is exactly unsigned a < b.
    assign lt   = diff[WIDTH];

    always_comb begin
        y_o     = '0;
        carry_o = 1'b0;
        unique case (op_i)
            OpAdd: begin
                y_o     = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
            end
            OpSub: begin
                y_o     = diff[WIDTH-1:0];
                carry_o = lt;
            end
            OpAnd:   y_o = a_i & b_i;
            OpOr:    y_o = a_i | b_i;
            OpXor:   y_o = a_i ^ b_i;
            OpNot:   y_o = ~a_i;
            OpPass:  y_o = a_i;
            OpSltu:  y_o = {{(WIDTH-1){1'b0}}, lt};
            default: y_o = '0;
        endcase
    end

    assign zero_o = (y_o == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters, result held in a one-deep
// valid/ready output register.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    alu_share_arbiter_if.slave bus
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             id_q, id_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

    logic             can_accept;
    logic             grant;
    logic             accept;
    op_e              sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] alu_y;
    logic             alu_carry, alu_zero;

    // Contention goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    assign can_accept     = (state_q == StEmpty) | bus.rsp_ready;
    assign bus.req0_ready = can_accept & ~grant;
    assign bus.req1_ready = can_accept & grant;
    assign accept         = can_accept & (grant ? bus.req1_valid : bus.req0_valid);

    assign sel_op = grant ? op_e'(bus.req1_op) : op_e'(bus.req0_op);
    assign sel_a  = grant ? bus.req1_a : bus.req0_a;
    assign sel_b  = grant ? bus.req1_b : bus.req0_b;

    alu_share_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i    (sel_op),
        .a_i     (sel_a),
        .b_i     (sel_b),
        .y_o     (alu_y),
        .carry_o (alu_carry),
        .zero_o  (alu_zero)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (bus.rsp_ready && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.rsp_valid = (state_q == StFull);
    end

    always_comb begin
        last_grant_d = last_grant_q;
        data_d       = data_q;
        id_d         = id_q;
        zero_d       = zero_q;
        carry_d      = carry_q;
        if (accept) begin
            last_grant_d = grant;
            data_d       = alu_y;
            id_d         = grant;
            zero_d       = alu_zero;
            carry_d      = alu_carry;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            data_q       <= '0;
            id_q         <= 1'b0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            id_q         <= id_d;
            zero_q       <= zero_d;
            carry_q      <= carry_d;
        end
    end

    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_zero  = zero_q;
    assign bus.rsp_carry = carry_q;

endmodule
